dm_responder: RTL and testbench

- Memory-side responder for the CPU data-memory request interface (chip-select, read, write, byte address, write data, store-width and load-width codes).
- Translates the MIPS data-segment address by subtracting BASE.
- Performs word, halfword and byte stores.
- Returns sign- or zero-extended load data after a programmable number of wait states, using a ready/err handshake.
- Replaces the zero-latency DMEM when the core runs with a stall-capable memory stage.

---
 rtl/dm_responder.sv | 212 +++++++++++++++++++++
 tb/tb_dm_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: wait-state data-memory responder for a stall-capable MIPS
// memory stage. Accepts one request per transfer, subtracts the data-segment
// base, performs word/half/byte stores or extended loads, and answers with a
// one-cycle ready pulse (err coincident on a bad request).
// Optional build macro DM_RESPONDER_BIG_ENDIAN_EN selects big-endian byte-lane
// mapping for loads and stores; the default build is little-endian.
module dm_responder #(
  parameter int          ADDR_W      = 11,
  parameter logic [31:0] BASE        = 32'h10010000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  ssignal,
  input  logic [2:0]  lsignal,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int         DEPTH     = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  ss_q, ss_d;
  logic [2:0]  ls_q, ls_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];
  logic        mem_we_s;

  logic [31:0]       off_s;
  logic [ADDR_W-3:0] widx_s;
  logic [31:0]       word_s;
  logic [4:0]        bsh_s;
  logic [4:0]        hsh_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic              req_err_s;
  logic [31:0]       store_word_s;
  logic [31:0]       load_val_s;

  assign off_s  = addr_q - BASE;
  assign widx_s = off_s[ADDR_W-1:2];
  assign word_s = mem_q[widx_s];

`ifdef DM_RESPONDER_BIG_ENDIAN_EN
  // lane 0 is the most significant byte of the stored word
  assign bsh_s = {~off_s[1:0], 3'b000};
  assign hsh_s = {~off_s[1], 4'b0000};
`else
  assign bsh_s = {off_s[1:0], 3'b000};
  assign hsh_s = {off_s[1], 4'b0000};
`endif

  assign byte_s = 8'(word_s >> bsh_s);
  assign half_s = 16'(word_s >> hsh_s);

  // Decode request legality: range, direction, width code and alignment
  always_comb begin
    req_err_s = 1'b0;
    if ((|off_s[31:ADDR_W]) || (rd_q == wr_q)) begin
      req_err_s = 1'b1;
    end else if (wr_q) begin
      case (ss_q)
        2'b00:   req_err_s = (off_s[1:0] != 2'b00);
        2'b01:   req_err_s = off_s[0];
        2'b10:   req_err_s = 1'b0;
        default: req_err_s = 1'b1;
      endcase
    end else begin
      case (ls_q)
        3'b000:         req_err_s = (off_s[1:0] != 2'b00);
        3'b001, 3'b010: req_err_s = off_s[0];
        3'b011, 3'b100: req_err_s = 1'b0;
        default:        req_err_s = 1'b1;
      endcase
    end
  end

  // Merge store data into the addressed lanes, preserving the others
  always_comb begin
    case (ss_q)
      2'b00:   store_word_s = wdata_q;
      2'b01:   store_word_s = (word_s & ~(32'h0000FFFF << hsh_s)) |
                              ({16'h0000, wdata_q[15:0]} << hsh_s);
      2'b10:   store_word_s = (word_s & ~(32'h000000FF << bsh_s)) |
                              ({24'h000000, wdata_q[7:0]} << bsh_s);
      default: store_word_s = word_s;
    endcase
  end

  // Select and extend load data
  always_comb begin
    case (ls_q)
      3'b000:  load_val_s = word_s;
      3'b001:  load_val_s = {{16{half_s[15]}}, half_s};
      3'b010:  load_val_s = {16'h0000, half_s};
      3'b011:  load_val_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  load_val_s = {24'h000000, byte_s};
      default: load_val_s = rdata_q;
    endcase
  end

  // Next-state, request capture and response generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ss_d     = ss_q;
    ls_d     = ls_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      // RESP also accepts so back-to-back requests lose no cycle
      S_IDLE, S_RESP: begin
        if (cs) begin
          addr_d  = addr;
          wdata_d = wdata;
          ss_d    = ssignal;
          ls_d    = lsignal;
          rd_d    = rd;
          wr_d    = wr;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        ready_d = 1'b1;
        if (req_err_s) begin
          err_d = 1'b1;
        end else if (wr_q) begin
          mem_we_s = 1'b1;
        end else begin
          rdata_d = load_val_s;
        end
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ss_q    <= 2'b00;
      ls_q    <= 3'b000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ss_q    <= ss_d;
      ls_q    <= ls_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[widx_s] <= store_word_s;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed testbench for dm_responder: one instance with one wait state and
// one with zero wait states for the back-to-back scenario.
module tb_dm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cs, rd, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  ssignal;
  logic [2:0]  lsignal;
  logic [31:0] rdata;
  logic        ready, err;

  logic        b_cs, b_rd, b_wr;
  logic [31:0] b_addr, b_wdata;
  logic [1:0]  b_ssignal;
  logic [2:0]  b_lsignal;
  logic [31:0] b_rdata;
  logic        b_ready, b_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dm_responder #(.ADDR_W(11), .BASE(32'h10010000), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .ssignal(ssignal), .lsignal(lsignal), .rdata(rdata), .ready(ready), .err(err)
  );

  dm_responder #(.ADDR_W(11), .BASE(32'h10010000), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .cs(b_cs), .rd(b_rd), .wr(b_wr), .addr(b_addr), .wdata(b_wdata),
    .ssignal(b_ssignal), .lsignal(b_lsignal), .rdata(b_rdata), .ready(b_ready), .err(b_err)
  );

  // One request on the 1-wait instance; latency counted in edges from the cs sample
  task automatic do_req(input logic i_rd, input logic i_wr, input logic [31:0] i_addr,
                        input logic [31:0] i_wdata, input logic [1:0] i_ss, input logic [2:0] i_ls,
                        output logic [31:0] o_rdata, output logic o_err, output int o_lat,
                        output logic o_pulse_ok);
    cs = 1'b1; rd = i_rd; wr = i_wr; addr = i_addr; wdata = i_wdata;
    ssignal = i_ss; lsignal = i_ls;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b1; wr = 1'b1; addr = 32'hFFFFFFFF; wdata = 32'h0BAD0BAD;
    ssignal = 2'b11; lsignal = 3'b111;
    o_lat = -1; o_rdata = rdata; o_err = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        o_lat = k + 1; o_rdata = rdata; o_err = err;
        break;
      end
    end
    @(posedge clk); #1;
    o_pulse_ok = (ready === 1'b0) && (err === 1'b0);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic e; int lat; logic p; logic seen;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", rdata); else pass_cnt++;
    total_cnt++; if (b_rdata !== 32'h0) $display("FAIL reset_rdata_b got=%h exp=00000000", b_rdata); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 1'b1, 32'h10010000, 32'h00000000, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b0 || lat != 3) $display("FAIL seed_store err=%b lat=%0d exp err=0 lat=3", e, lat); else pass_cnt++;
    // store abandoned by reset during WAIT
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 32'h10010000; wdata = 32'hDEADBEEF; ssignal = 2'b00;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen = seen | ready; end
    rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; seen = seen | ready; end
    total_cnt++; if (seen !== 1'b0) $display("FAIL reset_midwait_ready got=%b exp=0", seen); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010000, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (r !== 32'h00000000 || e !== 1'b0) $display("FAIL reset_no_write got=%h err=%b exp=00000000 err=0", r, e); else pass_cnt++;
  endtask

  task automatic test_word();
    logic [31:0] r; logic e; int lat; logic p;
    do_req(1'b0, 1'b1, 32'h10010004, 32'h12345678, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (lat != 3) $display("FAIL sw_latency got=%0d exp=3", lat); else pass_cnt++;
    total_cnt++; if (e !== 1'b0 || p !== 1'b1) $display("FAIL sw_err_pulse err=%b pulse_ok=%b exp 0/1", e, p); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010004, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (lat != 3) $display("FAIL lw_latency got=%0d exp=3", lat); else pass_cnt++;
    total_cnt++; if (r !== 32'h12345678 || e !== 1'b0) $display("FAIL lw_data got=%h err=%b exp=12345678 err=0", r, e); else pass_cnt++;
    total_cnt++; if (p !== 1'b1) $display("FAIL lw_pulse_width got=%b exp=1", p); else pass_cnt++;
  endtask

  task automatic test_subword();
    logic [31:0] r; logic e; int lat; logic p;
    do_req(1'b0, 1'b1, 32'h10010005, 32'h777777F0, 2'b10, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b0) $display("FAIL sb_err got=%b exp=0", e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010004, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (r !== 32'h1234F078) $display("FAIL sb_word got=%h exp=1234f078", r); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010005, 32'h0, 2'b00, 3'b011, r, e, lat, p);
    total_cnt++; if (r !== 32'hFFFFFFF0) $display("FAIL lb got=%h exp=fffffff0", r); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010005, 32'h0, 2'b00, 3'b100, r, e, lat, p);
    total_cnt++; if (r !== 32'h000000F0) $display("FAIL lbu got=%h exp=000000f0", r); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010006, 32'h0, 2'b00, 3'b001, r, e, lat, p);
    total_cnt++; if (r !== 32'h00001234) $display("FAIL lh_hi got=%h exp=00001234", r); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010004, 32'h0, 2'b00, 3'b001, r, e, lat, p);
    total_cnt++; if (r !== 32'hFFFFF078) $display("FAIL lh_lo got=%h exp=fffff078", r); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010004, 32'h0, 2'b00, 3'b010, r, e, lat, p);
    total_cnt++; if (r !== 32'h0000F078) $display("FAIL lhu_lo got=%h exp=0000f078", r); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h10010006, 32'h5555ABCD, 2'b01, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b0) $display("FAIL sh_err got=%b exp=0", e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010004, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (r !== 32'hABCDF078) $display("FAIL sh_word got=%h exp=abcdf078", r); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat; logic p;
    do_req(1'b1, 1'b0, 32'h10010002, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b1 || lat != 3) $display("FAIL lw_misalign err=%b lat=%0d exp err=1 lat=3", e, lat); else pass_cnt++;
    total_cnt++; if (r !== 32'hABCDF078) $display("FAIL err_rdata_hold got=%h exp=abcdf078", r); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h100107FC, 32'h11111111, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b0) $display("FAIL top_word_store err=%b exp=0", e); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h1000FFFC, 32'h99999999, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b1) $display("FAIL sw_underflow err=%b exp=1", e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h100107FC, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (r !== 32'h11111111 || e !== 1'b0) $display("FAIL underflow_no_write got=%h err=%b exp=11111111 err=0", r, e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010800, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b1) $display("FAIL lw_range err=%b exp=1", e); else pass_cnt++;
    do_req(1'b1, 1'b1, 32'h10010000, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b1) $display("FAIL rd_and_wr err=%b exp=1", e); else pass_cnt++;
    do_req(1'b0, 1'b0, 32'h10010000, 32'h0, 2'b00, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b1) $display("FAIL neither_rd_wr err=%b exp=1", e); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h10010000, 32'h0, 2'b11, 3'b000, r, e, lat, p);
    total_cnt++; if (e !== 1'b1) $display("FAIL ss_reserved err=%b exp=1", e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010000, 32'h0, 2'b00, 3'b101, r, e, lat, p);
    total_cnt++; if (e !== 1'b1) $display("FAIL ls_reserved err=%b exp=1", e); else pass_cnt++;
    total_cnt++; if (r !== 32'h11111111) $display("FAIL err_rdata_final got=%h exp=11111111", r); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] hist; logic [31:0] got [3]; logic any_err;
    hist = 10'b0; any_err = 1'b0;
    b_cs = 1'b1; b_rd = 1'b0; b_wr = 1'b1; b_ssignal = 2'b00; b_lsignal = 3'b000;
    b_addr = 32'h10010010; b_wdata = 32'hA1A1A1A1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      hist[e] = b_ready; any_err = any_err | b_err;
      if (e == 0) begin b_addr = 32'h10010014; b_wdata = 32'hB2B2B2B2; end
      else if (e == 2) begin b_addr = 32'h10010018; b_wdata = 32'hC3C3C3C3; end
      else if (e == 4) begin b_cs = 1'b0; b_wr = 1'b0; end
      else begin b_cs = b_cs; end
    end
    total_cnt++; if (hist !== 10'b0000101010) $display("FAIL b2b_store_ready got=%b exp=0000101010", hist); else pass_cnt++;
    hist = 10'b0;
    b_cs = 1'b1; b_rd = 1'b1; b_addr = 32'h10010010;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      hist[e] = b_ready; any_err = any_err | b_err;
      if (e == 1) got[0] = b_rdata;
      if (e == 3) got[1] = b_rdata;
      if (e == 5) got[2] = b_rdata;
      if (e == 0) b_addr = 32'h10010014;
      else if (e == 2) b_addr = 32'h10010018;
      else if (e == 4) begin b_cs = 1'b0; b_rd = 1'b0; end
      else b_cs = b_cs;
    end
    total_cnt++; if (hist !== 10'b0000101010) $display("FAIL b2b_load_ready got=%b exp=0000101010", hist); else pass_cnt++;
    total_cnt++; if (got[0] !== 32'hA1A1A1A1) $display("FAIL b2b_data0 got=%h exp=a1a1a1a1", got[0]); else pass_cnt++;
    total_cnt++; if (got[1] !== 32'hB2B2B2B2) $display("FAIL b2b_data1 got=%h exp=b2b2b2b2", got[1]); else pass_cnt++;
    total_cnt++; if (got[2] !== 32'hC3C3C3C3) $display("FAIL b2b_data2 got=%h exp=c3c3c3c3", got[2]); else pass_cnt++;
    total_cnt++; if (any_err !== 1'b0) $display("FAIL b2b_err got=%b exp=0", any_err); else pass_cnt++;
  endtask

  task automatic test_endian();
    logic [31:0] r; logic e; int lat; logic p; logic [31:0] exp_b; logic [31:0] exp_h;
`ifdef DM_RESPONDER_BIG_ENDIAN_EN
    exp_b = 32'h000000AA; exp_h = 32'h0000CCDD;
`else
    exp_b = 32'h000000DD; exp_h = 32'h0000AABB;
`endif
    do_req(1'b0, 1'b1, 32'h10010000, 32'hAABBCCDD, 2'b00, 3'b000, r, e, lat, p);
    do_req(1'b1, 1'b0, 32'h10010000, 32'h0, 2'b00, 3'b100, r, e, lat, p);
    total_cnt++; if (r !== exp_b) $display("FAIL endian_lbu got=%h exp=%h", r, exp_b); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10010002, 32'h0, 2'b00, 3'b010, r, e, lat, p);
    total_cnt++; if (r !== exp_h) $display("FAIL endian_lhu got=%h exp=%h", r, exp_h); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; ssignal = 2'b00; lsignal = 3'b000;
    b_cs = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    b_ssignal = 2'b00; b_lsignal = 3'b000;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back();
    test_endian();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
